register_file: RTL

- Synchronous register file plus status-flag register. Sits directly upstream of the ALU and closes the loop from it.
- Read ports A/B drive ALU in_a/in_b. The write port takes ALU out. The flag register captures ALU flags {overflow, negative, zero}.
- First storage stage of the datapath; the later controller/FSM sequences its enables.

---
 rtl/register_file.sv | 92 +++++++++
 1 files changed

// File: rtl/register_file.sv
// Register file with a registered status-flag register, feeding the ALU operands.
// Build option RF_BYPASS_EN: write-first collision handling (read-first otherwise).
module register_file #(
  parameter  int BW   = 4,
  parameter  int REGS = 8,
  localparam int AW   = $clog2(REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [BW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [BW-1:0] rd_data_a,
  output logic [BW-1:0] rd_data_b,
  input  logic          flags_en,
  input  logic [2:0]    flags_in,
  output logic [2:0]    flags_out
);

`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [BW-1:0] mem_q [REGS];
  logic [BW-1:0] mem_d [REGS];
  logic [BW-1:0] rd_a_q, rd_a_d;
  logic [BW-1:0] rd_b_q, rd_b_d;
  logic [2:0]    flags_q, flags_d;
  logic          hit_a_s, hit_b_s;

  // Storage next-state: a single write port, every address writable.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Read-port next-state; a collision forwards wr_data only in the write-first build.
  always_comb begin
    hit_a_s = BYPASS && wr_en && (wr_addr == rd_addr_a);
    hit_b_s = BYPASS && wr_en && (wr_addr == rd_addr_b);
    rd_a_d  = rd_a_q;
    rd_b_d  = rd_b_q;
    if (rd_en) begin
      rd_a_d = hit_a_s ? wr_data : mem_q[rd_addr_a];
      rd_b_d = hit_b_s ? wr_data : mem_q[rd_addr_b];
    end else begin
      rd_a_d = rd_a_q;
      rd_b_d = rd_b_q;
    end
  end

  // Flag capture, independent of the write port.
  always_comb begin
    flags_d = flags_q;
    if (flags_en) begin
      flags_d = flags_in;
    end else begin
      flags_d = flags_q;
    end
  end

  // State registers; reset clears everything at once without a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REGS; i++) begin
        mem_q[i] <= {BW{1'b0}};
      end
      rd_a_q  <= {BW{1'b0}};
      rd_b_q  <= {BW{1'b0}};
      flags_q <= 3'b000;
    end else begin
      mem_q   <= mem_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
      flags_q <= flags_d;
    end
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;
  assign flags_out = flags_q;

endmodule
